// File: rtl/req_ack_pkg.sv
// Shared constants and helpers for the req/ack responder.
package req_ack_pkg;

  localparam int REQ_ACK_MAX_DELAY = 16;
  localparam int REQ_ACK_CNT_W     = 16;

  // Width needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/req_ack_delay_line.sv
// DELAY-deep 1-bit shift register with async clear; the tail bit is the registered ack.
module req_ack_delay_line
  import req_ack_pkg::*;
#(
  parameter int DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic tail
);

  logic [DELAY-1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= (vld_pipe << 1) | DELAY'(din);
  end

  assign tail = vld_pipe[DELAY-1];

endmodule

// File: rtl/req_ack_responder.sv
// Fixed-latency handshake responder: each accepted req rise is acked DELAY cycles later.
// Define REQ_ACK_STATS_EN to add saturating ack_cnt/drop_cnt outputs.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DELAY   = 3,
  parameter int MAX_OUT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  output logic                         ack,
  output logic                         drop,
  output logic [cnt_w(MAX_OUT)-1:0]    outstanding,
`ifdef REQ_ACK_STATS_EN
  output logic [REQ_ACK_CNT_W-1:0]     ack_cnt,
  output logic [REQ_ACK_CNT_W-1:0]     drop_cnt,
`endif
  output logic                         busy
);

  localparam int OW = cnt_w(MAX_OUT);

  logic req_q;
  logic rise;
  logic retire;
  logic accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= req;
  end

  assign rise   = req & ~req_q;
  assign retire = ack;
  // outstanding >= retire always holds, so the subtraction cannot wrap.
  assign accept = rise &&
                  (((OW+1)'(outstanding) - (OW+1)'(retire)) < (OW+1)'(MAX_OUT));

  req_ack_delay_line #(.DELAY(DELAY)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (accept),
    .tail  (ack)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop        <= 1'b0;
      outstanding <= '0;
    end else begin
      drop <= rise & ~accept;
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign busy = (outstanding != '0);

`ifdef REQ_ACK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (ack  && ack_cnt  != '1) ack_cnt  <= ack_cnt  + 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: three configurations share one req stream,
// each checked every cycle against a due-time model plus directed literal checks.
module tb_req_ack_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;

  always #5 clk = ~clk;

  // A: DELAY=3 MAX_OUT=2, B: DELAY=6 MAX_OUT=2, C: DELAY=4 MAX_OUT=1
  logic       ack_a, ack_b, ack_c, drop_a, drop_b, drop_c, busy_a, busy_b, busy_c;
  logic [1:0] out_a, out_b;
  logic [0:0] out_c;
`ifdef REQ_ACK_STATS_EN
  logic [15:0] ackc_a, ackc_b, ackc_c, dropc_a, dropc_b, dropc_c;
`endif

  req_ack_responder #(.DELAY(3), .MAX_OUT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_a), .drop(drop_a),
    .outstanding(out_a),
`ifdef REQ_ACK_STATS_EN
    .ack_cnt(ackc_a), .drop_cnt(dropc_a),
`endif
    .busy(busy_a));

  req_ack_responder #(.DELAY(6), .MAX_OUT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_b), .drop(drop_b),
    .outstanding(out_b),
`ifdef REQ_ACK_STATS_EN
    .ack_cnt(ackc_b), .drop_cnt(dropc_b),
`endif
    .busy(busy_b));

  req_ack_responder #(.DELAY(4), .MAX_OUT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_c), .drop(drop_c),
    .outstanding(out_c),
`ifdef REQ_ACK_STATS_EN
    .ack_cnt(ackc_c), .drop_cnt(dropc_c),
`endif
    .busy(busy_c));

  int ack_d[3], drop_d[3], out_d[3], busy_d[3];
  assign ack_d[0] = int'(ack_a);   assign ack_d[1] = int'(ack_b);   assign ack_d[2] = int'(ack_c);
  assign drop_d[0] = int'(drop_a); assign drop_d[1] = int'(drop_b); assign drop_d[2] = int'(drop_c);
  assign out_d[0] = int'(out_a);   assign out_d[1] = int'(out_b);   assign out_d[2] = int'(out_c);
  assign busy_d[0] = int'(busy_a); assign busy_d[1] = int'(busy_b); assign busy_d[2] = int'(busy_c);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request is a due cycle (rise cycle + DELAY). A request
  // stays outstanding while its due cycle is still ahead of the current edge.
  int dl[3] = '{3, 6, 4};
  int ml[3] = '{2, 2, 1};
  int due[3][0:3];
  int cnt[3];
  int ack_e[3], drop_e[3];
  int cyc;
  logic req_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      req_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] = 0; ack_e[i] = 0; drop_e[i] = 0;
      end
    end else begin
      logic rise_m;
      cyc++;
      rise_m = req && !req_prev;
      req_prev = req;
      for (int i = 0; i < 3; i++) begin
        while (cnt[i] > 0 && due[i][0] <= cyc) begin
          for (int k = 0; k < 3; k++) due[i][k] = due[i][k+1];
          cnt[i]--;
        end
        drop_e[i] = 0;
        if (rise_m) begin
          if (cnt[i] < ml[i]) begin
            due[i][cnt[i]] = cyc + dl[i];
            cnt[i]++;
          end else begin
            drop_e[i] = 1;
          end
        end
        ack_e[i] = (cnt[i] > 0 && due[i][0] == cyc + 1) ? 1 : 0;
      end
    end
  end

  // Per-sample logs (index = posedge number at which the value is sampled).
  int ack_l[3][0:63], drop_l[3][0:63], out_l[3][0:63];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ack%0d", i),  ack_d[i],  ack_e[i]);
      chk($sformatf("drop%0d", i), drop_d[i], drop_e[i]);
      chk($sformatf("out%0d", i),  out_d[i],  cnt[i]);
      chk($sformatf("busy%0d", i), busy_d[i], (cnt[i] != 0) ? 1 : 0);
      if (cyc + 1 < 64) begin
        ack_l[i][cyc+1]  = ack_d[i];
        drop_l[i][cyc+1] = drop_d[i];
        out_l[i][cyc+1]  = out_d[i];
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 64; k++) begin
        ack_l[i][k] = 0; drop_l[i][k] = 0; out_l[i][k] = 0;
      end
  endtask

  function automatic int sum_ack(input int i);
    int s = 0;
    for (int k = 0; k < 64; k++) s += ack_l[i][k];
    return s;
  endfunction

  function automatic int sum_drop(input int i);
    int s = 0;
    for (int k = 0; k < 64; k++) s += drop_l[i][k];
    return s;
  endfunction

  function automatic int max_out(input int i);
    int m = 0;
    for (int k = 0; k < 64; k++) if (out_l[i][k] > m) m = out_l[i][k];
    return m;
  endfunction

  // pat[k] is the req level sampled at posedge k (k = 1..n).
  task automatic run_phase(input logic [31:0] pat, input int n);
    @(negedge clk); rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1; req = pat[1];
    for (int k = 2; k <= n; k++) begin
      @(negedge clk); req = pat[k];
    end
    @(negedge clk); req = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    logic [31:0] p;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack",  int'(ack_a),  0);
    chk("rst_drop", int'(drop_a), 0);
    chk("rst_out",  int'(out_a),  0);
    chk("rst_busy", int'(busy_a), 0);

    // single request
    p = 32'b10;
    run_phase(p, 2);
    chk("single_ack3", ack_l[0][3], 0);
    chk("single_ack4", ack_l[0][4], 1);
    chk("single_ack5", ack_l[0][5], 0);
    chk("single_out2", out_l[0][2], 1);
    chk("single_out4", out_l[0][4], 1);
    chk("single_out5", out_l[0][5], 0);
    chk("single_nack", sum_ack(0), 1);
    chk("single_drop", sum_drop(0), 0);

    // level hold for posedges 1..10
    p = 32'h7FE;
    run_phase(p, 10);
    chk("level_nack", sum_ack(0), 1);
    chk("level_ack4", ack_l[0][4], 1);

    // overlap: rises at 1 and 3
    p = 32'b1010;
    run_phase(p, 3);
    chk("ovl_ack4", ack_l[0][4], 1);
    chk("ovl_ack6", ack_l[0][6], 1);
    chk("ovl_nack", sum_ack(0), 2);
    chk("ovl_peak", max_out(0), 2);
    chk("ovl_drop", sum_drop(0), 0);

    // overflow on B: rises at 1, 3, 5
    p = 32'b101010;
    run_phase(p, 5);
    chk("ovf_ack7", ack_l[1][7], 1);
    chk("ovf_ack9", ack_l[1][9], 1);
    chk("ovf_nack", sum_ack(1), 2);
    chk("ovf_drop6", drop_l[1][6], 1);
    chk("ovf_ndrop", sum_drop(1), 1);
    chk("ovf_peak", max_out(1), 2);
`ifdef REQ_ACK_STATS_EN
    chk("ovf_ack_cnt",  int'(ackc_b),  2);
    chk("ovf_drop_cnt", int'(dropc_b), 1);
`endif

    // slot reuse on C: rises at 1 and 5
    p = 32'b100010;
    run_phase(p, 5);
    chk("reuse_ack5", ack_l[2][5], 1);
    chk("reuse_ack9", ack_l[2][9], 1);
    chk("reuse_nack", sum_ack(2), 2);
    chk("reuse_drop", sum_drop(2), 0);

    // reset mid-flight: rise at 1, rst_n low between posedges 2 and 3
    @(negedge clk); rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("mid_out_pre", int'(out_a), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack",  int'(ack_a),  0);
    chk("mid_drop", int'(drop_a), 0);
    chk("mid_out",  int'(out_a),  0);
    chk("mid_busy", int'(busy_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_nack", sum_ack(0), 0);
    chk("mid_busy_after", int'(busy_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
